// File: rtl/fpu_pkg.sv
// Shared FPU constants and types: FP16 field widths, significand/quotient sizes,
// and the iterative divider state encoding.
package fpu_pkg;

    localparam int MANT_W = 11;
    localparam int QW     = MANT_W + 2;
    localparam int CNT_W  = $clog2(QW);
    localparam int EXP_W  = 5;
    localparam int FRAC_W = 10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } div_state_e;

    // A significand is normalized when its hidden bit is set.
    function automatic logic is_normalized(input logic [MANT_W-1:0] mant);
        return mant[MANT_W-1];
    endfunction

endpackage

// File: rtl/fpu_div_step.sv
// One restoring-division iteration: trial subtract, keep or restore the
// remainder, then pre-shift it for the next quotient bit.
module fpu_div_step
    import fpu_pkg::*;
(
    input  logic [MANT_W:0]   rem,
    input  logic [MANT_W-1:0] divisor,
    output logic [MANT_W:0]   next_rem,
    output logic              qbit
);

    logic [MANT_W+1:0] trial_s;
    logic [MANT_W:0]   kept_s;

    // Trial subtraction with one guard bit so the sign is unambiguous.
    always_comb begin
        trial_s = {1'b0, rem} - {2'b00, divisor};
        qbit    = ~trial_s[MANT_W+1];
        if (qbit) begin
            kept_s = trial_s[MANT_W:0];
        end else begin
            kept_s = rem;
        end
        // kept_s < divisor < 2^MANT_W, so the top bit is always zero before the shift.
        next_rem = {kept_s[MANT_W-1:0], 1'b0};
    end

endmodule

// File: rtl/fpu_mant_divider.sv
// Iterative restoring divider for FP16 significands: one quotient bit per clock,
// start/busy/done handshake, sticky for inexact results, div-by-zero and
// non-normalized operand flags.
module fpu_mant_divider
    import fpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [MANT_W-1:0] op_a_mant,
    input  logic [MANT_W-1:0] op_b_mant,
    output logic              busy,
    output logic              done,
    output logic [QW-1:0]     quot,
    output logic              sticky,
    output logic              div_zero,
    output logic              norm_err
);

    div_state_e        state_r;
    logic [MANT_W:0]   rem_r;
    logic [MANT_W-1:0] divisor_r;
    logic [CNT_W-1:0]  count_r;

    logic [MANT_W:0]   next_rem_s;
    logic              qbit_s;
    logic              accept_s;
    logic              b_zero_s;
    logic              inputs_norm_s;

    fpu_div_step u_step (
        .rem      (rem_r),
        .divisor  (divisor_r),
        .next_rem (next_rem_s),
        .qbit     (qbit_s)
    );

    // Decode the start request and classify the operands.
    always_comb begin
        accept_s      = start & ~busy;
        b_zero_s      = (op_b_mant == {MANT_W{1'b0}});
        inputs_norm_s = is_normalized(op_a_mant) & is_normalized(op_b_mant);
    end

    // Divider FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            quot      <= {QW{1'b0}};
            sticky    <= 1'b0;
            div_zero  <= 1'b0;
            norm_err  <= 1'b0;
            rem_r     <= {(MANT_W+1){1'b0}};
            divisor_r <= {MANT_W{1'b0}};
            count_r   <= {CNT_W{1'b0}};
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        div_zero  <= 1'b0;
                        norm_err  <= 1'b0;
                        sticky    <= 1'b0;
                        quot      <= {QW{1'b0}};
                        rem_r     <= {1'b0, op_a_mant};
                        divisor_r <= op_b_mant;
                        count_r   <= CNT_W'(QW - 1);
                        // Zero divisor wins over the normalization check.
                        if (b_zero_s) begin
                            div_zero <= 1'b1;
                            quot     <= {QW{1'b1}};
                            done     <= 1'b1;
                        end else if (!inputs_norm_s) begin
                            norm_err <= 1'b1;
                            done     <= 1'b1;
                        end else begin
                            state_r <= RUN;
                            busy    <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    rem_r <= next_rem_s;
                    quot  <= {quot[QW-2:0], qbit_s};
                    if (count_r == {CNT_W{1'b0}}) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        sticky  <= (next_rem_s != {(MANT_W+1){1'b0}});
                    end else begin
                        count_r <= count_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
